spi_slave_regs: RTL

SPI responder (slave) for the 16-bit command/data frames issued by the board's SPI master. It serves a small 8-byte register file. The block runs entirely on the system clock: SCLK, CS_N and SDI are oversampled through synchronizers, so no second clock domain exists. It sits behind the DE10-LITE header pins and stands in for a sensor so the master path can be exercised on-board, and it also serves as a generic slave peripheral.

---
 rtl/spi_slave_regs_if.sv | 26 ++
 rtl/spi_slave_regs.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regs_if.sv
// SPI pin, local-update and write-report signals of spi_slave_regs, with the
// slave view for the responder and the master view for whatever drives it.
interface spi_slave_regs_if;
  logic       spi_sclk_i;
  logic       spi_cs_n_i;
  logic       spi_sdi_i;
  logic       spi_sdo_o;
  logic       spi_sdo_oe_o;
  logic       upd_i;
  logic [2:0] upd_addr_i;
  logic [7:0] upd_data_i;
  logic       wr_stb_o;
  logic [5:0] wr_addr_o;
  logic [7:0] wr_data_o;
  logic       frame_err_o;

  modport slave (
    input  spi_sclk_i, spi_cs_n_i, spi_sdi_i, upd_i, upd_addr_i, upd_data_i,
    output spi_sdo_o, spi_sdo_oe_o, wr_stb_o, wr_addr_o, wr_data_o, frame_err_o
  );

  modport master (
    output spi_sclk_i, spi_cs_n_i, spi_sdi_i, upd_i, upd_addr_i, upd_data_i,
    input  spi_sdo_o, spi_sdo_oe_o, wr_stb_o, wr_addr_o, wr_data_o, frame_err_o
  );
endinterface

// File: rtl/spi_slave_regs.sv
// Mode-3 SPI responder over an 8-byte register file, pins oversampled on clk_i (strobes 3 cycles after pins,
// commit 4); no backpressure, the SPI master sets the pace. SPI_SLAVE_AUTOINC_EN enables burst access.
module spi_slave_regs #(
  parameter logic [7:0] DEVID = 8'hE5
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  spi_slave_regs_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  sclk_sr, cs_sr;
  logic [1:0]  sdi_sr;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_q, tx_q, pend_data;
  logic [5:0]  addr_q, pend_addr, wr_addr_q;
  logic [7:0]  wr_data_q;
  logic        rw_q, sdo_q, more_q, commit_q, wr_stb_q, frame_err_q;
  logic [7:0]  regs_q [0:7];
  logic        cmd_done, byte_done, abort;

  wire sclk_rise = sclk_sr[1] & ~sclk_sr[2];
  wire sclk_fall = ~sclk_sr[1] & sclk_sr[2];
  wire cs_fall   = ~cs_sr[1] & cs_sr[2];
  wire cs_rise   = cs_sr[1] & ~cs_sr[2];
  wire sdi_s     = sdi_sr[1];
  wire [7:0] rx_byte = {shift_q[6:0], sdi_s};
  wire in_frame  = (state_q == S_CMD) || (state_q == S_DATA);
  wire shift_en  = in_frame && sclk_rise && !cs_rise;
  wire rd_phase  = (state_q == S_DATA) && rw_q;
  wire tx_en     = rd_phase && sclk_fall && !cs_rise;

  function automatic logic [7:0] rd_byte(input logic [5:0] a);
    if (a == 6'd0)             return DEVID;
    else if (a[5:3] == 3'd0)   return regs_q[a[2:0]];
    else                       return 8'h00;
  endfunction

  // Idle levels: SCLK high (mode 3), CS_N deasserted.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sclk_sr <= 3'b111;
      cs_sr   <= 3'b111;
      sdi_sr  <= 2'b00;
    end else begin
      sclk_sr <= {sclk_sr[1:0], bus.spi_sclk_i};
      cs_sr   <= {cs_sr[1:0], bus.spi_cs_n_i};
      sdi_sr  <= {sdi_sr[0], bus.spi_sdi_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_done  = 1'b0;
    byte_done = 1'b0;
    abort     = 1'b0;
    unique case (state_q)
      S_IDLE: if (cs_fall) state_d = S_CMD;
      S_CMD: begin
        if (cs_rise) begin
          state_d = S_IDLE;
          abort   = 1'b1;
        end else if (sclk_rise && bit_cnt == 3'd7) begin
          state_d  = S_DATA;
          cmd_done = 1'b1;
        end
      end
      S_DATA: begin
        if (cs_rise) begin
          state_d = S_IDLE;
          // Clean end only on a byte boundary after at least one data byte.
          abort   = !(more_q && bit_cnt == 3'd0);
        end else if (sclk_rise && bit_cnt == 3'd7) begin
          byte_done = 1'b1;
`ifndef SPI_SLAVE_AUTOINC_EN
          state_d   = S_DONE;
`endif
        end
      end
      S_DONE: if (cs_sr[1]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bit_cnt     <= 3'd0;
      shift_q     <= 8'h00;
      tx_q        <= 8'h00;
      rw_q        <= 1'b0;
      addr_q      <= 6'd0;
      sdo_q       <= 1'b0;
      more_q      <= 1'b0;
      commit_q    <= 1'b0;
      pend_addr   <= 6'd0;
      pend_data   <= 8'h00;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= 6'd0;
      wr_data_q   <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      commit_q    <= 1'b0;
      frame_err_q <= abort;
      wr_stb_q    <= commit_q;
      if (commit_q) begin
        wr_addr_q <= pend_addr;
        wr_data_q <= pend_data;
      end
      if (state_q == S_IDLE && cs_fall) begin
        bit_cnt <= 3'd0;
        more_q  <= 1'b0;
      end
      if (shift_en) begin
        shift_q <= rx_byte;
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (cmd_done) begin
        rw_q   <= rx_byte[7];
        addr_q <= rx_byte[5:0];
        tx_q   <= rd_byte(rx_byte[5:0]);
        sdo_q  <= 1'b0;
      end
      if (tx_en) begin
        sdo_q <= tx_q[7];
        tx_q  <= {tx_q[6:0], 1'b0};
      end
      if (byte_done) begin
        more_q    <= 1'b1;
        commit_q  <= ~rw_q;
        pend_addr <= addr_q;
        pend_data <= rx_byte;
`ifdef SPI_SLAVE_AUTOINC_EN
        addr_q    <= addr_q + 6'd1;
        tx_q      <= rd_byte(addr_q + 6'd1);
`endif
      end
    end
  end

  // The SPI commit is applied last so it overrides a same-address local write.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= 8'h00;
    end else begin
      if (bus.upd_i && bus.upd_addr_i != 3'd0)
        regs_q[bus.upd_addr_i] <= bus.upd_data_i;
      if (commit_q && pend_addr[5:3] == 3'd0 && pend_addr[2:0] != 3'd0)
        regs_q[pend_addr[2:0]] <= pend_data;
    end
  end

  assign bus.spi_sdo_o    = rd_phase & sdo_q;
  assign bus.spi_sdo_oe_o = rd_phase;
  assign bus.wr_stb_o     = wr_stb_q;
  assign bus.wr_addr_o    = wr_addr_q;
  assign bus.wr_data_o    = wr_data_q;
  assign bus.frame_err_o  = frame_err_q;

endmodule
